// File: rtl/isa_burst_reader.sv
// Instruction-fetch DDR read engine: turns a cache fill request into one or more
// DDR bursts of at most MAX_BURST beats and streams one instruction per beat back.
module isa_burst_reader #(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DDR_DATA_WIDTH = 64,
  parameter int ISA_WIDTH      = 30,
  parameter int MAX_BURST      = 64,
  parameter int ADDR_STEP      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      isa_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] isa_read_addr,
  input  logic [9:0]                isa_read_len,
  output logic [ISA_WIDTH-1:0]      instruction_to_cache,
  output logic                      isa_data_valid,
  output logic [9:0]                rd_cnt_isa,
  output logic                      ddr_rdy,
  output logic [3:0]                state_isa_reader,
  input  logic                      ddr_init_done,
  output logic                      rd_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  output logic [9:0]                rd_burst_len,
  input  logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
  input  logic                      rd_burst_data_valid,
  input  logic                      rd_burst_finish
);

  localparam logic [3:0] ST_IDLE  = 4'd1;
  localparam logic [3:0] ST_BURST = 4'd2;
  localparam logic [3:0] ST_GAP   = 4'd3;
  localparam logic [3:0] ST_DONE  = 4'd4;

  localparam logic [9:0]                MAX_LEN = 10'(MAX_BURST);
  localparam logic [DDR_ADDR_WIDTH-1:0] STEP    = DDR_ADDR_WIDTH'(ADDR_STEP);

  logic [3:0]                state_reg, state_next;
  logic [DDR_ADDR_WIDTH-1:0] cur_addr_reg, cur_addr_next;
  logic [9:0]                remaining_reg, remaining_next;
  logic [9:0]                beats_reg;
  logic [9:0]                cnt_reg;
  logic [9:0]                len_next;
  logic                      accept;
  logic                      beat_ok;

  assign state_isa_reader = state_reg;
  assign rd_cnt_isa       = cnt_reg;

  // Upper DDR data bits carry nothing for the instruction path.
  generate
    if (DDR_DATA_WIDTH > ISA_WIDTH) begin : g_unused_data
      logic unused_data_bits;
      assign unused_data_bits = ^rd_burst_data[DDR_DATA_WIDTH-1:ISA_WIDTH];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    cur_addr_next  = cur_addr_reg;
    remaining_next = remaining_reg;
    accept         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (isa_read_req && ddr_init_done) begin
          accept         = 1'b1;
          cur_addr_next  = isa_read_addr;
          remaining_next = isa_read_len;
          state_next     = (isa_read_len == 10'd0) ? ST_DONE : ST_BURST;
        end
      end
      ST_BURST: begin
        if (rd_burst_finish) begin
          remaining_next = remaining_reg - rd_burst_len;
          cur_addr_next  = cur_addr_reg + DDR_ADDR_WIDTH'(rd_burst_len) * STEP;
          state_next     = (remaining_next == 10'd0 || !isa_read_req) ? ST_DONE : ST_GAP;
        end
      end
      ST_GAP:  state_next = isa_read_req ? ST_BURST : ST_DONE;
      ST_DONE: if (!isa_read_req) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign len_next = (remaining_next < MAX_LEN) ? remaining_next : MAX_LEN;

  // Overrun beats past the requested burst length are never counted or delivered.
  assign beat_ok = (state_reg == ST_BURST) && rd_burst_data_valid && (beats_reg < rd_burst_len);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg            <= ST_IDLE;
      cur_addr_reg         <= '0;
      remaining_reg        <= '0;
      beats_reg            <= '0;
      cnt_reg              <= '0;
      instruction_to_cache <= '0;
      isa_data_valid       <= 1'b0;
      ddr_rdy              <= 1'b0;
      rd_burst_req         <= 1'b0;
      rd_burst_addr        <= '0;
      rd_burst_len         <= '0;
    end else begin
      state_reg     <= state_next;
      cur_addr_reg  <= cur_addr_next;
      remaining_reg <= remaining_next;
      beats_reg     <= (state_reg == ST_BURST) ? beats_reg + {9'd0, beat_ok} : 10'd0;

      if (accept)
        cnt_reg <= '0;
      else if (beat_ok && cnt_reg != 10'h3FF)
        cnt_reg <= cnt_reg + 10'd1;

      isa_data_valid <= beat_ok;
      if (beat_ok)
        instruction_to_cache <= rd_burst_data[ISA_WIDTH-1:0];

      // Burst address/length are loaded on entry to BURST and stay put through it.
      rd_burst_req <= (state_next == ST_BURST);
      if (state_next == ST_BURST) begin
        rd_burst_addr <= cur_addr_next;
        rd_burst_len  <= len_next;
      end

      ddr_rdy <= (state_next == ST_IDLE) && ddr_init_done;
    end
  end

endmodule
